store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side companion to the data memory load path. Accepts SB/SH/SW requests from the MEM stage.
- The word memory has only a full-word write strobe, so sub-word stores are done as read-modify-write: read the word, merge the byte/half lane, write the word back.
- SW bypasses the read.
- Sits between the pipeline MEM stage and the 32-bit data memory port. It stalls the pipeline via a valid/ready handshake.

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory.
- DATA_W, 32, data word width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  DM_ADDRESS  byte address (ALU result LSBs)
- req_wdata  in  DATA_W  store data (rs2)
- req_funct3  in  3  instruction bits 14:12
- mem_raddr  out  DM_ADDRESS  word-aligned read address
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_raddr
- mem_waddr  out  DM_ADDRESS  word-aligned write address
- mem_wdata  out  DATA_W  merged write word
- mem_wr  out  1  full-word write strobe
- done  out  1  1-cycle pulse, store retired
- misalign_err  out  1  1-cycle pulse, request dropped

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_wr=0, done=0, misalign_err=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
- States: IDLE, RD, MERGE, WR.
- req_ready=1 only in IDLE. A handshake (req_valid & req_ready) registers addr, wdata and funct3.
- Accept transitions:
  - funct3=010 (SW), aligned: IDLE -> WR.
  - 000 (SB), or 001 (SH) aligned: IDLE -> RD.
  - Misaligned or unsupported funct3: see below.
- RD (1 cycle): mem_raddr = {addr[DM_ADDRESS-1:2],2'b00}. -> MERGE.
- MERGE (1 cycle): capture mem_rdata and build merged word.
  - SB: replace byte lane addr[1:0] with wdata[7:0].
  - SH: replace half addr[1] with wdata[15:0].
  - Other bits unchanged. -> WR.
- WR (1 cycle): mem_wr=1, mem_waddr = aligned address, mem_wdata = merged word (SW: wdata unmodified). done=1 in the same cycle. -> IDLE.
- Latency from accept edge to mem_wr: SW 1 cycle, SB/SH 3 cycles. Throughput is one store per latency+1 cycles, since there is no accept while busy.
- Misaligned means SH with addr[0]=1, or SW with addr[1:0]!=0. Handling is set by the optional feature.
- Unsupported funct3 (anything other than 000/001/010): request consumed, misalign_err pulses next cycle, no write, stays IDLE.
- mem_wr is never asserted outside WR. Exactly one write per accepted legal store.
- Reset asserted mid-operation: immediate return to IDLE. Any pending write is discarded and no mem_wr is issued.
- req_valid while busy: ignored. Requester must hold the request until req_ready.

Optional Feature:
- Macro STORE_MISALIGN_TRAP_EN.
- Defined: misaligned SH/SW is consumed without a write. misalign_err pulses the cycle after accept. State stays IDLE.
- Undefined: misaligned addresses are silently aligned down.
  - SH uses half addr[1] and ignores addr[0].
  - SW writes the aligned word.
  - misalign_err is tied 0.

Test Plan:
- SW addr 0x010, wdata 0xDEADBEEF: mem_wr 1 cycle after accept, waddr 0x010, wdata 0xDEADBEEF, done same cycle, no mem_raddr cycle.
- SB addr 0x023, wdata 0x000000AB, memory word 0x11223344: raddr 0x020; mem_wr 3 cycles after accept with wdata 0xAB223344.
- SH addr 0x042, wdata 0x0000CAFE, memory word 0x55667788: wdata 0xCAFE7788 at waddr 0x040.
- Misaligned SH addr 0x041:
  - With STORE_MISALIGN_TRAP_EN: misalign_err pulse, no mem_wr.
  - Without it: write 0x5566xxxx lane 0 merged, i.e. 0x5566CAFE for the word above.
- rst_n low during MERGE of an SB: no mem_wr ever. After release, req_ready=1 and a new SW completes normally.
- Back-to-back req_valid held high through an SB then an SW: second request accepted only when req_ready returns. Exactly two mem_wr pulses, in order.

Source files
------------

// File: rtl/store_merge_unit.sv
// ---------------------------------------------------------------------------
// store_merge_unit
//
// Store-side companion to the data-memory load path. It accepts SB/SH/SW
// requests from the MEM stage and turns them into full-word writes. The
// memory has only a full-word write strobe, so sub-word stores go through
// read-modify-write (RD -> MERGE -> WR). SW skips the read and goes straight
// to WR. The pipeline stalls on req_ready, which is high only in IDLE.
//
// Optional feature (compile-time macro):
//   STORE_MISALIGN_TRAP_EN  defined   : misaligned SH/SW is consumed without a
//                                       write and misalign_err pulses.
//                           undefined : misaligned addresses are aligned down
//                                       and never raise misalign_err.
//   Unsupported funct3 raises misalign_err in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready store request handshake
//   req_addr            byte address of the store
//   req_wdata           store data (rs2)
//   req_funct3          instruction bits 14:12 (000 SB, 001 SH, 010 SW)
//   mem_raddr           word-aligned read address, meaningful during RD
//   mem_rdata           read data, valid one cycle after mem_raddr
//   mem_waddr/mem_wdata word-aligned write address and merged write word
//   mem_wr              full-word write strobe, high only in WR
//   done                one-cycle pulse when a store retires (with mem_wr)
//   misalign_err        one-cycle pulse when a request is dropped
// ---------------------------------------------------------------------------
module store_merge_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32   // only 32 is supported
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic [DM_ADDRESS-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DM_ADDRESS-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wr,
    output logic                  done,
    output logic                  misalign_err
);

    typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    state_e                  state_q;
    logic [1:0]              lane_q;       // byte offset of the sub-word store
    logic                    half_q;       // 1: SH, 0: SB
    logic [15:0]             sub_wdata_q;  // only the low half is ever merged
    logic [DM_ADDRESS-1:0]   raddr_q;
    logic [DM_ADDRESS-1:0]   waddr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    wr_q;
    logic                    done_q;
    logic                    err_q;

    logic                    accept;
    logic                    unsupported;
    logic                    drop;
    logic [DM_ADDRESS-1:0]   aligned_addr;
    logic [DATA_W-1:0]       merge_word;

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid && req_ready;
    assign aligned_addr = {req_addr[DM_ADDRESS-1:2], 2'b00};
    assign unsupported  = (req_funct3 != F3_SB) && (req_funct3 != F3_SH) &&
                          (req_funct3 != F3_SW);

`ifdef STORE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_funct3 == F3_SH) && req_addr[0]) ||
                        ((req_funct3 == F3_SW) && (req_addr[1:0] != 2'b00));
    assign drop       = unsupported || misaligned;
`else
    // Misaligned SH/SW falls through: the aligned address and the lane
    // selection on addr[1] discard the offending low bits.
    assign drop       = unsupported;
`endif

    // Lane merge of the registered store data into the word read back.
    always_comb begin
        // NOTE: default assignment first so every path drives merge_word and no latch is inferred.
        merge_word = mem_rdata;
        if (half_q) begin
            if (lane_q[1]) merge_word[31:16] = sub_wdata_q;
            else           merge_word[15:0]  = sub_wdata_q;
        end else begin
            case (lane_q)
                2'd0:    merge_word[7:0]   = sub_wdata_q[7:0];
                2'd1:    merge_word[15:8]  = sub_wdata_q[7:0];
                2'd2:    merge_word[23:16] = sub_wdata_q[7:0];
                default: merge_word[31:24] = sub_wdata_q[7:0];
            endcase
        end
    end

    // Single-process FSM; all memory-side outputs are registered so mem_wr
    // and done are high exactly while the state register holds WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            half_q      <= 1'b0;
            sub_wdata_q <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (drop) begin
                            err_q <= 1'b1;
                        end else if (req_funct3 == F3_SW) begin
                            waddr_q <= aligned_addr;
                            wdata_q <= req_wdata;
                            wr_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= WR;
                        end else begin
                            raddr_q     <= aligned_addr;
                            waddr_q     <= aligned_addr;
                            lane_q      <= req_addr[1:0];
                            half_q      <= (req_funct3 == F3_SH);
                            sub_wdata_q <= req_wdata[15:0];
                            state_q     <= RD;
                        end
                    end
                end
                RD: state_q <= MERGE;
                MERGE: begin
                    wdata_q <= merge_word;
                    wr_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= WR;
                end
                WR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_raddr    = raddr_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wr       = wr_q;
    assign done         = done_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// ---------------------------------------------------------------------------
// tb_store_merge_unit
//
// Directed stimulus with hand-computed expected writes. The driver pushes the
// expected response (write or error pulse, address, data, cycle) into a
// queue when a request is accepted; a monitor on the falling edge pops and
// compares whenever the DUT raises mem_wr or misalign_err. A small read-only
// word memory answers mem_raddr with one cycle of latency.
// ---------------------------------------------------------------------------
module tb_store_merge_unit;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [2:0]    req_funct3 = '0;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata = '0;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_wr;
    logic          done;
    logic          misalign_err;

    store_merge_unit #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .done(done), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-only word memory: fixed contents, so every expected word is a
    // constant merge of the preloaded value.
    logic [31:0] rom [128];
    always @(posedge clk) mem_rdata <= rom[mem_raddr[AW-1:2]];

    typedef struct {
        bit          is_wr;
        logic [8:0]  addr;
        logic [31:0] data;
        int          cyc;       // offset from the accept edge, then absolute
        bit          chk_raddr;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write expected: SW retires in the cycle after accept, SB/SH two later.
    function automatic exp_t ew(input logic [8:0] a, input logic [31:0] d, input bit sub);
        exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d;
        e.cyc = sub ? 2 : 0; e.chk_raddr = sub;
        return e;
    endfunction

    function automatic exp_t ee();
        exp_t e;
        e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.cyc = 0; e.chk_raddr = 1'b0;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance
    // with req_valid still high.
    task automatic send(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3,
                        input exp_t e, input bit push);
        int n;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'b0, req_ready}, 32'd1);
        end else begin
            e.cyc = cyc + 1 + e.cyc;
            if (push) sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_wr"},    {31'b0, mem_wr}, 32'd0);
        check({tag, "_done"},  {31'b0, done}, 32'd0);
        check({tag, "_err"},   {31'b0, misalign_err}, 32'd0);
        check({tag, "_raddr"}, {23'b0, mem_raddr}, 32'd0);
        check({tag, "_waddr"}, {23'b0, mem_waddr}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mem_wr || done) check("done_with_wr", {31'b0, done}, {31'b0, mem_wr});
        if (mem_wr || misalign_err) begin
            if (sb.size() == 0) begin
                check("spurious_wr",  {31'b0, mem_wr}, 32'd0);
                check("spurious_err", {31'b0, misalign_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("kind_wr",  {31'b0, mem_wr}, {31'b0, e.is_wr});
                check("kind_err", {31'b0, misalign_err}, {31'b0, !e.is_wr});
                check("cycle",    cyc, e.cyc);
                if (e.is_wr) begin
                    check("waddr", {23'b0, mem_waddr}, {23'b0, e.addr});
                    check("wdata", mem_wdata, e.data);
                    if (e.chk_raddr) check("raddr", {23'b0, mem_raddr}, {23'b0, e.addr});
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) rom[i] = 32'h0;
        rom[9'h020 >> 2] = 32'h11223344;
        rom[9'h040 >> 2] = 32'h55667788;
        rom[9'h060 >> 2] = 32'hA5A5A5A5;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic stores.
        send(9'h010, 32'hDEADBEEF, 3'b010, ew(9'h010, 32'hDEADBEEF, 0), 1); idle(2);
        send(9'h023, 32'h000000AB, 3'b000, ew(9'h020, 32'hAB223344, 1), 1); idle(2);
        send(9'h020, 32'hFFFFFF5A, 3'b000, ew(9'h020, 32'h1122335A, 1), 1); idle(2);
        send(9'h061, 32'h0000003C, 3'b000, ew(9'h060, 32'hA5A53CA5, 1), 1); idle(2);
        send(9'h062, 32'h00000077, 3'b000, ew(9'h060, 32'hA577A5A5, 1), 1); idle(2);
        send(9'h042, 32'h0000CAFE, 3'b001, ew(9'h040, 32'hCAFE7788, 1), 1); idle(2);
        send(9'h060, 32'hFFFF1234, 3'b001, ew(9'h060, 32'hA5A51234, 1), 1); idle(2);

        // Misaligned SH / SW.
`ifdef STORE_MISALIGN_TRAP_EN
        send(9'h041, 32'h0000CAFE, 3'b001, ee(), 1); idle(2);
        send(9'h016, 32'h12345678, 3'b010, ee(), 1); idle(2);
`else
        send(9'h041, 32'h0000CAFE, 3'b001, ew(9'h040, 32'h5566CAFE, 1), 1); idle(2);
        send(9'h016, 32'h12345678, 3'b010, ew(9'h014, 32'h12345678, 0), 1); idle(2);
`endif

        // Unsupported funct3: consumed, error pulse, no write.
        send(9'h000, 32'h11111111, 3'b100, ee(), 1); idle(1);
        check("ready_after_unsup", {31'b0, req_ready}, 32'd1);
        send(9'h004, 32'h22222222, 3'b011, ee(), 1); idle(2);

        // Reset during MERGE of an SB: the write must never appear.
        send(9'h023, 32'h000000EE, 3'b000, ee(), 0);   // now in RD
        req_valid = 1'b0;
        @(negedge clk);                                // now in MERGE
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);
        send(9'h1FC, 32'h0BADF00D, 3'b010, ew(9'h1FC, 32'h0BADF00D, 0), 1); idle(2);

        // Back-to-back with req_valid held high: SB then SW.
        send(9'h062, 32'h00000099, 3'b000, ew(9'h060, 32'hA599A5A5, 1), 1);
        check("busy_not_ready", {31'b0, req_ready}, 32'd0);
        send(9'h100, 32'hCAFEBABE, 3'b010, ew(9'h100, 32'hCAFEBABE, 0), 1);
        idle(2);

        // Drain and make sure nothing further appears.
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
